// File: rtl/cpu_pkg.sv
// Shared encodings for the cpu_core datapath: opcode/funct values, field
// positions and the ALU operation set.
package cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam int OP_LSB = 26;
   localparam int RS_LSB = 21;
   localparam int RT_LSB = 16;
   localparam int RD_LSB = 11;
   localparam int SH_LSB = 6;

   typedef enum logic [2:0] {
      ALU_NONE,
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT,
      ALU_SLL
   } alu_op_e;

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/cpu_core_regfile.sv
// 32x32 register file: two async read ports, one sync write port.
// Reset loads r_i = i; r0 always reads zero and ignores writes.
module regfile (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);

   logic [31:0] regs [32];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'(i);
      end else if (we && wa != 5'd0) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
   assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/cpu_core.sv
// Two-stage execution core: ROM fetch into IR/PCx on edge k, combinational
// execute, then register write-back and next-PC capture on edge k+1.
module cpu_core
   import cpu_pkg::*;
#(
   parameter int IMEM_DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] pc,
   output logic [15:0] pc_out,
   output logic [31:0] rs,
   output logic [31:0] rt,
   output logic [31:0] rd
);

   function automatic logic [31:0] rom_word(input logic [5:0] a);
      case (a)
         6'd0:    return 32'h0022_1820; // ADD r3,r1,r2
         6'd1:    return 32'h00E2_3022; // SUB r6,r7,r2
         6'd6:    return 32'h018A_4824; // AND r9,r12,r10
         6'd10:   return 32'h0002_58C0; // SLL r11,r2,3
         6'd14:   return 32'h1021_0005; // BEQ r1,r1,+5
         default: return 32'h0000_0000;
      endcase
   endfunction

   logic [31:0] ir;
   logic [15:0] pcx;
   logic [31:0] fetch_word;

   assign fetch_word = ({26'd0, pc[5:0]} < 32'(IMEM_DEPTH)) ? rom_word(pc[5:0]) : 32'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir  <= 32'd0;
         pcx <= 16'd0;
      end else begin
         ir  <= fetch_word;
         pcx <= pc;
      end
   end

   logic [5:0]  op, funct;
   logic [4:0]  rs_idx, rt_idx, rd_idx, shamt;
   logic [15:0] imm;

   assign op     = ir[OP_LSB +: 6];
   assign rs_idx = ir[RS_LSB +: 5];
   assign rt_idx = ir[RT_LSB +: 5];
   assign rd_idx = ir[RD_LSB +: 5];
   assign shamt  = ir[SH_LSB +: 5];
   assign funct  = ir[5:0];
   assign imm    = ir[15:0];

   alu_op_e    alu_op;
   logic       wr_en, use_imm, is_beq;
   logic [4:0] wr_addr;

   // Unknown op/funct falls through with ALU_NONE and no write.
   always_comb begin
      alu_op  = ALU_NONE;
      wr_en   = 1'b0;
      wr_addr = rd_idx;
      use_imm = 1'b0;
      is_beq  = 1'b0;
      case (op)
         OP_RTYPE: begin
            wr_en = 1'b1;
            case (funct)
               FN_ADD:  alu_op = ALU_ADD;
               FN_SUB:  alu_op = ALU_SUB;
               FN_AND:  alu_op = ALU_AND;
               FN_OR:   alu_op = ALU_OR;
               FN_SLT:  alu_op = ALU_SLT;
               FN_SLL:  alu_op = ALU_SLL;
               default: wr_en  = 1'b0;
            endcase
         end
         OP_BEQ: begin
            alu_op = ALU_SUB;
            is_beq = 1'b1;
         end
         OP_ADDI: begin
            alu_op  = ALU_ADD;
            use_imm = 1'b1;
            wr_en   = 1'b1;
            wr_addr = rt_idx;
         end
         default: ;
      endcase
   end

   logic [31:0] rs_val, rt_val, opb, alu_res;

   regfile u_rf (
      .clk   (clk),
      .rst_n (rst_n),
      .ra1   (rs_idx),
      .ra2   (rt_idx),
      .we    (wr_en),
      .wa    (wr_addr),
      .wd    (alu_res),
      .rd1   (rs_val),
      .rd2   (rt_val)
   );

   assign opb = use_imm ? sext16(imm) : rt_val;

   always_comb begin
      alu_res = 32'd0;
      case (alu_op)
         ALU_ADD: alu_res = rs_val + opb;
         ALU_SUB: alu_res = rs_val - opb;
         ALU_AND: alu_res = rs_val & opb;
         ALU_OR:  alu_res = rs_val | opb;
         ALU_SLT: alu_res = {31'd0, $signed(rs_val) < $signed(opb)};
         ALU_SLL: alu_res = rt_val << shamt;
         default: alu_res = 32'd0;
      endcase
   end

   // Sign-extending imm to 16 bits is the identity, so the offset adds directly.
   logic        taken;
   logic [15:0] next_pc;

   assign taken   = is_beq && (rs_val == rt_val);
   assign next_pc = pcx + 16'd1 + (taken ? imm : 16'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_out <= 16'd0;
      else        pc_out <= next_pc;
   end

   assign rs = rs_val;
   assign rt = rt_val;
   assign rd = alu_res;

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: directed program walk, random PC stream
// and async reset, all scored against an instruction-level reference model.
module tb_cpu_core;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] pc;
   logic [15:0] pc_out;
   logic [31:0] rs, rt, rd;

   cpu_core #(.IMEM_DEPTH(64)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .pc     (pc),
      .pc_out (pc_out),
      .rs     (rs),
      .rt     (rt),
      .rd     (rd)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef enum {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_SLL, K_BEQ, K_ADDI} kind_t;
   typedef struct {
      kind_t       k;
      int          s, t, d, sh;
      logic [15:0] imm;
   } ins_t;

   logic [31:0] mreg [32];
   logic [15:0] pend_next;
   logic        pend_wr;
   int          pend_wa;
   logic [31:0] pend_val;

   function automatic ins_t prog(input logic [15:0] p);
      ins_t i;
      i = '{k: K_SLL, s: 0, t: 0, d: 0, sh: 0, imm: 16'd0};
      case (p[5:0])
         6'd0:  i = '{k: K_ADD, s: 1,  t: 2,  d: 3,  sh: 0, imm: 16'd0};
         6'd1:  i = '{k: K_SUB, s: 7,  t: 2,  d: 6,  sh: 0, imm: 16'd0};
         6'd6:  i = '{k: K_AND, s: 12, t: 10, d: 9,  sh: 0, imm: 16'd0};
         6'd10: i = '{k: K_SLL, s: 0,  t: 2,  d: 11, sh: 3, imm: 16'd0};
         6'd14: i = '{k: K_BEQ, s: 1,  t: 1,  d: 0,  sh: 0, imm: 16'd5};
         default: ;
      endcase
      return i;
   endfunction

   function automatic logic [31:0] rdreg(input int n);
      return (n == 0) ? 32'd0 : mreg[n];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mreg[i] = 32'(i);
      // After reset the NOP at PCx=0 is in flight: next-PC 1, no visible write.
      pend_next = 16'd1;
      pend_wr   = 1'b0;
      pend_wa   = 0;
      pend_val  = 32'd0;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   // One instruction: drive pc, clock it in, score the previous instruction's
   // write-back/next-PC and the current instruction's operands/result.
   task automatic step(input logic [15:0] p);
      ins_t        i;
      logic [31:0] a, b, r;
      logic [15:0] nxt;
      logic        wr;
      int          wa;
      @(negedge clk);
      pc = p;
      @(posedge clk);
      #1;
      if (pend_wr && pend_wa != 0) mreg[pend_wa] = pend_val;
      check($sformatf("pc_out after pc=%h", p), {16'd0, pc_out}, {16'd0, pend_next});
      for (int n = 0; n < 32; n++)
         check($sformatf("r%0d", n), dut.u_rf.regs[n], (n == 0) ? 32'd0 : mreg[n]);
      i  = prog(p);
      a  = rdreg(i.s);
      b  = rdreg(i.t);
      wr = 1'b1;
      wa = i.d;
      nxt = p + 16'd1;
      r  = 32'd0;
      case (i.k)
         K_ADD:  r = a + b;
         K_SUB:  r = a - b;
         K_AND:  r = a & b;
         K_OR:   r = a | b;
         K_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         K_SLL:  r = b << i.sh;
         K_ADDI: begin r = a + {{16{i.imm[15]}}, i.imm}; wa = i.t; end
         K_BEQ:  begin
            r  = a - b;
            wr = 1'b0;
            if (a == b) nxt = p + 16'd1 + i.imm;
         end
         default: ;
      endcase
      check($sformatf("rs pc=%h", p), rs, a);
      check($sformatf("rt pc=%h", p), rt, b);
      check($sformatf("rd pc=%h", p), rd, r);
      pend_next = nxt;
      pend_wr   = wr;
      pend_wa   = wa;
      pend_val  = r;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      pc    = 16'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset pc_out", {16'd0, pc_out}, 32'd0);
      check("reset rs", rs, 32'd0);
      check("reset rt", rt, 32'd0);
      check("reset rd", rd, 32'd0);
      check("reset r5", dut.u_rf.regs[5], 32'd5);
      check("reset r31", dut.u_rf.regs[31], 32'd31);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_program();
      repeat (4) step(16'd0);
      repeat (2) step(16'd1);
      step(16'd6);
      step(16'd10);
      step(16'd14);
      step(16'hFFFF);
      step(16'd0);
      check("wrap pc_out", {16'd0, pc_out}, 32'd0);
   endtask

   task automatic test_back_to_back();
      int          sel;
      logic [15:0] p;
      for (int n = 0; n < 300; n++) begin
         sel = int'($urandom_range(0, 5));
         p   = 16'($urandom);
         case (sel)
            0: p[5:0] = 6'd0;
            1: p[5:0] = 6'd1;
            2: p[5:0] = 6'd6;
            3: p[5:0] = 6'd10;
            4: p[5:0] = 6'd14;
            default: ;
         endcase
         step(p);
      end
   endtask

   task automatic test_async_reset();
      step(16'd0);
      step(16'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async pc_out", {16'd0, pc_out}, 32'd0);
      check("async rs", rs, 32'd0);
      check("async rt", rt, 32'd0);
      check("async rd", rd, 32'd0);
      check("async r3", dut.u_rf.regs[3], 32'd3);
      check("async r6", dut.u_rf.regs[6], 32'd6);
      check("async r11", dut.u_rf.regs[11], 32'd11);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step(16'd2);
      check("no write r3", dut.u_rf.regs[3], 32'd3);
      step(16'd2);
      check("nop pc_out", {16'd0, pc_out}, 32'd3);
      check("r0 zero", dut.u_rf.regs[0], 32'd0);
   endtask

   initial begin
      test_reset();
      test_program();
      test_back_to_back();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
